// File: rtl/router_pkg.sv
// Shared definitions for the router packet framer: state encoding and header layout.
package router_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] COLLECT = 3'd1;
    localparam logic [2:0] HEADER  = 3'd2;
    localparam logic [2:0] PAYLOAD = 3'd3;
    localparam logic [2:0] PARITY  = 3'd4;
    localparam logic [2:0] GAP     = 3'd5;

    localparam logic [1:0] ADDR_ILLEGAL = 2'd3;

    localparam int unsigned HDR_LEN_MSB  = 7;
    localparam int unsigned HDR_LEN_LSB  = 2;
    localparam int unsigned HDR_ADDR_MSB = 1;
    localparam int unsigned HDR_ADDR_LSB = 0;

    function automatic logic [7:0] calc_header(input logic [5:0] len, input logic [1:0] addr);
        logic [7:0] hdr;
        hdr = 8'h00;
        hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
        return hdr;
    endfunction

endpackage

// File: rtl/router_pkt_framer_if.sv
// Command, payload and router-side packet signals of the framer.
// err_inj exists only when PKT_FRAMER_ERRINJ_EN is defined.
interface router_pkt_framer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] pl_data;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] pkt_data;
    logic       pkt_done;
    logic       cmd_drop;
`ifdef PKT_FRAMER_ERRINJ_EN
    logic       err_inj;
`endif

    // master: traffic source plus router busy; slave: the framer
    modport master (
`ifdef PKT_FRAMER_ERRINJ_EN
        output err_inj,
`endif
        output cmd_valid, cmd_addr, cmd_len, pl_valid, pl_data, busy,
        input  cmd_ready, pl_ready, pkt_valid, pkt_data, pkt_done, cmd_drop
    );

    modport slave (
`ifdef PKT_FRAMER_ERRINJ_EN
        input  err_inj,
`endif
        input  cmd_valid, cmd_addr, cmd_len, pl_valid, pl_data, busy,
        output cmd_ready, pl_ready, pkt_valid, pkt_data, pkt_done, cmd_drop
    );

endinterface

// File: rtl/framer_buf.sv
// Payload buffer: synchronous write, combinational read, contents not reset.
module framer_buf #(
    parameter int unsigned DEPTH = 63
) (
    input  logic       clock,
    input  logic       we,
    input  logic [5:0] waddr,
    input  logic [7:0] wdata,
    input  logic [5:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_framer.sv
// Store-and-forward packet framer feeding the 1x3 router input port.
// Optional parity error injection is enabled by defining PKT_FRAMER_ERRINJ_EN.
module router_pkt_framer
    import router_pkg::*;
#(
    parameter int unsigned MAX_LEN = 63,
    parameter int unsigned GAP_CYC = 2
) (
    input logic                clock,
    input logic                reset,
    router_pkt_framer_if.slave bus
);

    localparam logic [6:0] MAX_LEN_W = 7'(MAX_LEN);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYC - 1);

    logic [2:0] state_q, state_d;
    logic [5:0] len_q, len_d;
    logic [1:0] addr_q, addr_d;
    logic [5:0] count_q, count_d;
    logic [5:0] rd_ptr_q, rd_ptr_d;
    logic [7:0] parity_q, parity_d;
    logic [3:0] gap_q, gap_d;
    logic       err_q, err_d;

    logic       cmd_ready_q, cmd_ready_d;
    logic       pl_ready_q, pl_ready_d;
    logic       pkt_valid_q, pkt_valid_d;
    logic [7:0] pkt_data_q, pkt_data_d;
    logic       pkt_done_q, pkt_done_d;
    logic       cmd_drop_q, cmd_drop_d;

    logic       err_in;
    logic       cmd_fire;
    logic       cmd_legal;
    logic       pl_fire;
    logic       buf_we;
    logic [7:0] buf_rdata;

`ifdef PKT_FRAMER_ERRINJ_EN
    assign err_in = bus.err_inj;
`else
    assign err_in = 1'b0;
`endif

    assign cmd_fire  = bus.cmd_valid && cmd_ready_q;
    assign cmd_legal = (bus.cmd_addr != ADDR_ILLEGAL) && (bus.cmd_len != 6'd0) &&
                       ({1'b0, bus.cmd_len} <= MAX_LEN_W);
    assign pl_fire   = bus.pl_valid && pl_ready_q;

    framer_buf #(
        .DEPTH (MAX_LEN)
    ) u_buf (
        .clock (clock),
        .we    (buf_we),
        .waddr (count_q),
        .wdata (bus.pl_data),
        .raddr (rd_ptr_d),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= 6'd0;
            addr_q      <= 2'd0;
            count_q     <= 6'd0;
            rd_ptr_q    <= 6'd0;
            parity_q    <= 8'h00;
            gap_q       <= 4'd0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            pl_ready_q  <= 1'b0;
            pkt_valid_q <= 1'b0;
            pkt_data_q  <= 8'h00;
            pkt_done_q  <= 1'b0;
            cmd_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            parity_q    <= parity_d;
            gap_q       <= gap_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            pl_ready_q  <= pl_ready_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_data_q  <= pkt_data_d;
            pkt_done_q  <= pkt_done_d;
            cmd_drop_q  <= cmd_drop_d;
        end
    end

    // busy only matters in the transmit states; elsewhere it is never looked at
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        addr_d   = addr_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        parity_d = parity_q;
        gap_d    = gap_q;
        err_d    = err_q;
        buf_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_fire && cmd_legal) begin
                    len_d    = bus.cmd_len;
                    addr_d   = bus.cmd_addr;
                    parity_d = calc_header(bus.cmd_len, bus.cmd_addr);
                    count_d  = 6'd0;
                    rd_ptr_d = 6'd0;
                    err_d    = err_in;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (pl_fire) begin
                    buf_we   = 1'b1;
                    parity_d = parity_q ^ bus.pl_data;
                    count_d  = count_q + 6'd1;
                    if (count_q == len_q - 6'd1) begin
                        state_d = HEADER;
                    end
                end
            end
            HEADER: begin
                if (!bus.busy) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!bus.busy) begin
                    if (rd_ptr_q == len_q - 6'd1) begin
                        state_d = PARITY;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 6'd1;
                    end
                end
            end
            PARITY: begin
                if (!bus.busy) begin
                    gap_d   = 4'd0;
                    state_d = (GAP_CYC == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                gap_d = gap_q + 4'd1;
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so the registers line up with state_q.
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        pl_ready_d  = (state_d == COLLECT);
        pkt_valid_d = (state_d == HEADER) || (state_d == PAYLOAD);
        pkt_done_d  = (state_q == PARITY) && (state_d != PARITY);
        cmd_drop_d  = (state_q == IDLE) && cmd_fire && !cmd_legal;
        pkt_data_d  = 8'h00;
        case (state_d)
            HEADER:  pkt_data_d = calc_header(len_d, addr_d);
            PAYLOAD: pkt_data_d = buf_rdata;
            PARITY:  pkt_data_d = parity_d ^ {8{err_d}};
            default: pkt_data_d = 8'h00;
        endcase
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.pl_ready  = pl_ready_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.pkt_data  = pkt_data_q;
    assign bus.pkt_done  = pkt_done_q;
    assign bus.cmd_drop  = cmd_drop_q;

endmodule

// File: tb/tb_router_pkt_framer.sv
// Self-checking bench for router_pkt_framer: command table, corner sequences, random traffic.
module tb_router_pkt_framer;

    localparam int unsigned MAX_LEN = 63;
    localparam int unsigned GAP_CYC = 2;

    typedef struct {
        logic       v;
        logic [7:0] d;
    } beat_t;

    typedef struct {
        logic [1:0] addr;
        logic [5:0] len;
        bit         legal;
        logic [7:0] hdr;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    int          errors = 0;
    int          checks = 0;
    beat_t       exp_q[$];
    logic [7:0]  last_par = 8'h00;
    bit          mon_en = 1'b1;
    bit          busy_auto = 1'b0;
    int unsigned busy_pct = 0;

    router_pkt_framer_if bus();

    router_pkt_framer #(
        .MAX_LEN (MAX_LEN),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic fail(input string name, input int got, input int want);
        checks++;
        errors++;
        $display("FAIL %s got=%0d want=%0d", name, got, want);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference: header = len*4 + addr, then the bytes, then XOR of everything (inverted on err).
    function automatic void model_packet(input logic [1:0] addr, input logic [5:0] len,
                                         input logic [7:0] data[$], input bit err);
        beat_t      b;
        logic [7:0] par;
        b.v = 1'b1;
        b.d = 8'((int'(len) * 4) + int'(addr));
        par = b.d;
        exp_q.push_back(b);
        foreach (data[i]) begin
            b.d = data[i];
            par = par ^ data[i];
            exp_q.push_back(b);
        end
        b.v = 1'b0;
        b.d = err ? ~par : par;
        exp_q.push_back(b);
    endfunction

    initial begin
        bus.busy = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (busy_auto) bus.busy = ($urandom_range(99) < busy_pct);
        end
    end

    // A byte is consumed at the edge following a negedge where busy is low.
    always @(negedge clock) begin
        if (!reset && mon_en) begin
            if (bus.pkt_done) begin
                if (exp_q.size() == 0 || exp_q[0].v) begin
                    fail("pkt_done_unexpected", 1, 0);
                end else begin
                    check("parity_byte", last_par, exp_q[0].d);
                    void'(exp_q.pop_front());
                end
            end
            if (bus.pkt_valid && !bus.busy) begin
                if (exp_q.size() == 0) begin
                    fail("byte_unexpected", int'(bus.pkt_data), -1);
                end else begin
                    check("pkt_valid_phase", bus.pkt_valid, exp_q[0].v);
                    check("pkt_byte", bus.pkt_data, exp_q[0].d);
                    void'(exp_q.pop_front());
                end
            end
            if (!bus.pkt_valid && !bus.busy) last_par = bus.pkt_data;
        end
    end

    task automatic send_cmd(input logic [1:0] addr, input logic [5:0] len, input bit err);
        int n = 0;
        while (!bus.cmd_ready && n < 200) begin
            step();
            n++;
        end
        if (!bus.cmd_ready) fail("cmd_ready_timeout", 0, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
`ifdef PKT_FRAMER_ERRINJ_EN
        bus.err_inj   = err;
`else
        if (err) fail("err_inj_unsupported", 1, 0);
`endif
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_payload(input logic [7:0] data[$], input int unsigned gap_pct);
        foreach (data[i]) begin
            bit acc = 1'b0;
            int n = 0;
            while ($urandom_range(99) < gap_pct && n < 8) begin
                bus.pl_valid = 1'b0;
                step();
                n++;
            end
            bus.pl_valid = 1'b1;
            bus.pl_data  = data[i];
            n = 0;
            while (!acc && n < 200) begin
                acc = bus.pl_ready;
                step();
                n++;
            end
            if (!acc) fail("pl_accept_timeout", i, 1);
        end
        bus.pl_valid = 1'b0;
    endtask

    task automatic run_packet(input logic [1:0] addr, input logic [5:0] len,
                              input logic [7:0] data[$], input bit err,
                              input int unsigned gap_pct, input logic [7:0] hdr);
        model_packet(addr, len, data, err);
        send_cmd(addr, len, err);
        send_payload(data, gap_pct);
        check("hdr_latency_valid", bus.pkt_valid, 1'b1);
        check("hdr_latency_data", bus.pkt_data, hdr);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            fail(name, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic drop_cmd(input logic [1:0] addr, input logic [5:0] len);
        send_cmd(addr, len, 1'b0);
        check("drop_pulse", bus.cmd_drop, 1'b1);
        check("drop_ready", bus.cmd_ready, 1'b1);
        check("drop_no_valid", bus.pkt_valid, 1'b0);
        step();
        check("drop_pulse_end", bus.cmd_drop, 1'b0);
        check("drop_still_idle", bus.pl_ready, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[8];
        logic [7:0] d[$];
        logic [7:0] t1[$];
        int         n;

        vecs[0] = '{2'd1, 6'd3,  1'b1, 8'h0D};
        vecs[1] = '{2'd3, 6'd5,  1'b0, 8'h00};
        vecs[2] = '{2'd0, 6'd0,  1'b0, 8'h00};
        vecs[3] = '{2'd2, 6'd63, 1'b1, 8'hFE};
        vecs[4] = '{2'd0, 6'd1,  1'b1, 8'h04};
        vecs[5] = '{2'd3, 6'd0,  1'b0, 8'h00};
        vecs[6] = '{2'd2, 6'd7,  1'b1, 8'h1E};
        vecs[7] = '{2'd0, 6'd40, 1'b1, 8'hA0};
        t1 = '{8'hA1, 8'hB2, 8'hC3};

        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 2'd0;
        bus.cmd_len   = 6'd0;
        bus.pl_valid  = 1'b0;
        bus.pl_data   = 8'h00;
`ifdef PKT_FRAMER_ERRINJ_EN
        bus.err_inj   = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        check("rst_pkt_valid", bus.pkt_valid, 1'b0);
        check("rst_pkt_data", bus.pkt_data, 8'h00);
        check("rst_pl_ready", bus.pl_ready, 1'b0);
        check("rst_pkt_done", bus.pkt_done, 1'b0);
        check("rst_cmd_drop", bus.cmd_drop, 1'b0);
        reset = 1'b0;
        step();
        check("rst_cmd_ready", bus.cmd_ready, 1'b1);

        // pl_valid while idle is ignored
        bus.pl_valid = 1'b1;
        bus.pl_data  = 8'h55;
        check("idle_pl_ready", bus.pl_ready, 1'b0);
        step();
        check("idle_pl_ready2", bus.pl_ready, 1'b0);
        bus.pl_valid = 1'b0;

        // Basic packet, no backpressure; then exactly GAP_CYC idle cycles before cmd_ready.
        busy_auto = 1'b0;
        bus.busy  = 1'b0;
        run_packet(2'd1, 6'd3, t1, 1'b0, 0, 8'h0D);
        n = 0;
        while (!bus.pkt_done && n < 200) begin
            step();
            n++;
        end
        check("done_seen", bus.pkt_done, 1'b1);
        check("gap_ready0", bus.cmd_ready, 1'b0);
        step();
        check("done_one_cycle", bus.pkt_done, 1'b0);
        check("gap_ready1", bus.cmd_ready, 1'b0);
        check("gap_valid", bus.pkt_valid, 1'b0);
        step();
        check("gap_ready2", bus.cmd_ready, 1'b1);
        wait_drain("drain_basic");

        // Busy held 4 cycles on the first payload byte
        run_packet(2'd1, 6'd3, t1, 1'b0, 0, 8'h0D);
        step();
        bus.busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("busy_hold_valid", bus.pkt_valid, 1'b1);
            check("busy_hold_data", bus.pkt_data, 8'hA1);
            step();
        end
        bus.busy = 1'b0;
        wait_drain("drain_busy");

        // Command table
        busy_auto = 1'b1;
        busy_pct  = 25;
        foreach (vecs[i]) begin
            if (vecs[i].legal) begin
                d.delete();
                for (int j = 0; j < int'(vecs[i].len); j++) begin
                    d.push_back((i == 3) ? 8'(j) : 8'($urandom));
                end
                run_packet(vecs[i].addr, vecs[i].len, d, 1'b0, (i == 3) ? 40 : 10, vecs[i].hdr);
                wait_drain("drain_table");
            end else begin
                drop_cmd(vecs[i].addr, vecs[i].len);
            end
        end

        // Reset while presenting payload byte 2
        busy_auto = 1'b0;
        bus.busy  = 1'b0;
        d = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};
        run_packet(2'd0, 6'd5, d, 1'b0, 0, 8'h14);
        step();
        step();
        step();
        check("payload_byte2", bus.pkt_data, 8'h32);
        #2;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("async_rst_valid", bus.pkt_valid, 1'b0);
        check("async_rst_data", bus.pkt_data, 8'h00);
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        step();
        check("post_rst_ready", bus.cmd_ready, 1'b1);
        busy_auto = 1'b1;
        busy_pct  = 40;
        run_packet(2'd1, 6'd3, t1, 1'b0, 20, 8'h0D);
        wait_drain("drain_post_rst");

`ifdef PKT_FRAMER_ERRINJ_EN
        run_packet(2'd1, 6'd3, t1, 1'b1, 0, 8'h0D);
        wait_drain("drain_errinj");
`endif

        // Random traffic
        busy_pct = 30;
        for (int it = 0; it < 30; it++) begin
            int unsigned r = $urandom_range(99);
            if (r < 15) begin
                if (r < 8) drop_cmd(2'd3, 6'($urandom_range(63)));
                else       drop_cmd(2'($urandom_range(2)), 6'd0);
            end else begin
                logic [1:0] a   = 2'($urandom_range(2));
                logic [5:0] len = (r > 90) ? 6'd63 : 6'($urandom_range(16, 1));
                bit         err = 1'b0;
`ifdef PKT_FRAMER_ERRINJ_EN
                err = $urandom_range(1) == 1;
`endif
                d.delete();
                for (int j = 0; j < int'(len); j++) d.push_back(8'($urandom));
                run_packet(a, len, d, err, 25, 8'((int'(len) * 4) + int'(a)));
                wait_drain("drain_random");
            end
        end

        busy_auto = 1'b0;
        bus.busy  = 1'b0;
        repeat (5) step();
        check("final_idle_ready", bus.cmd_ready, 1'b1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
